// File: rtl/quiz_prompt_sequencer.sv
// Frame-synchronous quiz prompt sequencer: drives one-hot prompt enables,
// accepts one answer per prompt, keeps a saturating score and a per-question frame timer.
module quiz_prompt_sequencer #(
    parameter int NUM_Q       = 4,
    parameter int QW          = 2,
    parameter int TIME_FRAMES = 600,
    parameter int FRAME_LINE  = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       hcount_i,
    input  logic [9:0]       vcount_i,
    input  logic             start_i,
    input  logic             ans_valid_i,
    input  logic             ans_correct_i,
    output logic             ans_ready_o,
    output logic [NUM_Q-1:0] q_en_o,
    output logic [QW-1:0]    q_idx_o,
    output logic [4:0]       score_o,
    output logic [9:0]       time_left_o,
    output logic             timeout_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SHOW    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [9:0]    TIME_LOAD = 10'(TIME_FRAMES);
    localparam logic [9:0]    TICK_LINE = 10'(FRAME_LINE);
    localparam logic [QW-1:0] IDX_ONE   = QW'(1);
    localparam logic [QW-1:0] IDX_LAST  = QW'(NUM_Q - 1);

    state_t             state_q;
    logic               ans_ready_q;
    logic [NUM_Q-1:0]   q_en_q;
    logic [QW-1:0]      q_idx_q;
    logic [4:0]         score_q;
    logic [9:0]         time_left_q;
    logic               timeout_q;
    logic               done_q;
    logic               frame_tick_s;
    logic               accept_s;

    function automatic logic [NUM_Q-1:0] onehot(input logic [QW-1:0] idx);
        onehot = {{(NUM_Q-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [4:0] sat_add(input logic [4:0] val, input logic inc);
        if (inc && (val != 5'd31)) begin
            sat_add = val + 5'd1;
        end else begin
            sat_add = val;
        end
    endfunction

    assign frame_tick_s = (vcount_i == TICK_LINE) && (hcount_i == 10'd0);
    assign accept_s     = ans_valid_i && ans_ready_q;

    // Sequencer state and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ans_ready_q <= 1'b0;
            q_en_q      <= '0;
            q_idx_q     <= '0;
            score_q     <= 5'd0;
            time_left_q <= 10'd0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q     <= S_ARM;
                        q_idx_q     <= '0;
                        score_q     <= 5'd0;
                        time_left_q <= TIME_LOAD;
                        done_q      <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (frame_tick_s) begin
                        q_en_q      <= onehot(q_idx_q);
                        ans_ready_q <= 1'b1;
                        state_q     <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    // An accept always beats an expiring tick in the same cycle
                    if (accept_s) begin
                        score_q     <= sat_add(score_q, ans_correct_i);
                        ans_ready_q <= 1'b0;
                        state_q     <= S_ADVANCE;
                    end else if (frame_tick_s) begin
                        if (time_left_q <= 10'd1) begin
                            time_left_q <= 10'd0;
                            timeout_q   <= 1'b1;
                            ans_ready_q <= 1'b0;
                            state_q     <= S_ADVANCE;
                        end else begin
                            time_left_q <= time_left_q - 10'd1;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (frame_tick_s) begin
                        if (q_idx_q == IDX_LAST) begin
                            q_en_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            q_idx_q     <= q_idx_q + IDX_ONE;
                            q_en_q      <= onehot(q_idx_q + IDX_ONE);
                            time_left_q <= TIME_LOAD;
                            ans_ready_q <= 1'b1;
                            state_q     <= S_SHOW;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    ans_ready_q <= 1'b0;
                    q_en_q      <= '0;
                    q_idx_q     <= '0;
                    score_q     <= 5'd0;
                    time_left_q <= 10'd0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign ans_ready_o = ans_ready_q;
    assign q_en_o      = q_en_q;
    assign q_idx_o     = q_idx_q;
    assign score_o     = score_q;
    assign time_left_o = time_left_q;
    assign timeout_o   = timeout_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_quiz_prompt_sequencer.sv
// Directed bench: a full-length timer instance and a 3-frame timer instance share clock, reset and frame timing.
module tb_quiz_prompt_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hcount, vcount;
    logic       start, ans_valid, ans_valid_s, ans_correct;

    logic       rdy, tmo, dn, rdy_s, tmo_s, dn_s;
    logic [3:0] qen, qen_s;
    logic [1:0] qidx, qidx_s;
    logic [4:0] score, score_s;
    logic [9:0] tl, tl_s;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    quiz_prompt_sequencer #(.NUM_Q(4), .QW(2), .TIME_FRAMES(600), .FRAME_LINE(480)) dut (
        .clk(clk), .rst(rst), .hcount_i(hcount), .vcount_i(vcount), .start_i(start),
        .ans_valid_i(ans_valid), .ans_correct_i(ans_correct), .ans_ready_o(rdy),
        .q_en_o(qen), .q_idx_o(qidx), .score_o(score), .time_left_o(tl),
        .timeout_o(tmo), .done_o(dn)
    );

    quiz_prompt_sequencer #(.NUM_Q(4), .QW(2), .TIME_FRAMES(3), .FRAME_LINE(480)) dut_s (
        .clk(clk), .rst(rst), .hcount_i(hcount), .vcount_i(vcount), .start_i(start),
        .ans_valid_i(ans_valid_s), .ans_correct_i(ans_correct), .ans_ready_o(rdy_s),
        .q_en_o(qen_s), .q_idx_o(qidx_s), .score_o(score_s), .time_left_o(tl_s),
        .timeout_o(tmo_s), .done_o(dn_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vcount = 10'd480;
        hcount = 10'd0;
        cyc();
        vcount = 10'd12;
        hcount = 10'd7;
    endtask

    initial begin
        rst = 1'b1; hcount = 10'd7; vcount = 10'd12;
        start = 1'b0; ans_valid = 1'b0; ans_valid_s = 1'b0; ans_correct = 1'b0;

        // T1: reset dominates toggling inputs
        cyc();
        start = 1'b1; ans_valid = 1'b1; ans_correct = 1'b1;
        frame();
        cyc();
        check_val("rst_qen", 32'(qen), 32'd0);
        check_val("rst_flags", {29'd0, rdy, tmo, dn}, 32'd0);
        check_val("rst_score_tl", {17'd0, score, tl}, 32'd0);
        check_val("rst_qidx", 32'(qidx), 32'd0);
        start = 1'b0; ans_valid = 1'b0; ans_correct = 1'b0;
        rst = 1'b0;
        cyc();
        frame();
        cyc();
        check_val("idle_no_start_qen", 32'(qen), 32'd0);
        check_val("idle_no_start_tl", 32'(tl), 32'd0);

        // T2: start loads, prompt appears only on the tick edge
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("arm_tl", 32'(tl), 32'd600);
        check_val("arm_tl_s", 32'(tl_s), 32'd3);
        check_val("arm_qen", 32'(qen), 32'd0);
        check_val("arm_ready", 32'(rdy), 32'd0);
        vcount = 10'd480; hcount = 10'd1;
        cyc();
        vcount = 10'd479; hcount = 10'd0;
        cyc();
        check_val("near_tick_qen", 32'(qen), 32'd0);
        frame();
        check_val("show_qen", 32'(qen), 32'd1);
        check_val("show_ready", 32'(rdy), 32'd1);
        check_val("show_qidx", 32'(qidx), 32'd0);

        // T3: correct answer, then advance on next tick
        ans_valid = 1'b1; ans_correct = 1'b1;
        cyc();
        ans_valid = 1'b0;
        check_val("ans_score", 32'(score), 32'd1);
        check_val("ans_ready_low", 32'(rdy), 32'd0);
        check_val("adv_holds_qen", 32'(qen), 32'd1);
        ans_valid = 1'b1;
        cyc();
        ans_valid = 1'b0;
        check_val("ignored_ans_score", 32'(score), 32'd1);
        frame();
        check_val("adv_qidx", 32'(qidx), 32'd1);
        check_val("adv_qen", 32'(qen), 32'd2);
        check_val("adv_tl", 32'(tl), 32'd600);
        check_val("s_tl_2", 32'(tl_s), 32'd2);

        // T4: short timer runs out unanswered
        frame();
        check_val("s_tl_1", 32'(tl_s), 32'd1);
        check_val("s_no_tmo_yet", 32'(tmo_s), 32'd0);
        frame();
        check_val("s_tl_0", 32'(tl_s), 32'd0);
        check_val("s_tmo_pulse", 32'(tmo_s), 32'd1);
        check_val("s_tmo_ready", 32'(rdy_s), 32'd0);
        check_val("s_tmo_score", 32'(score_s), 32'd0);
        check_val("s_tmo_qen", 32'(qen_s), 32'd1);
        check_val("tl_597_pre", 32'(tl), 32'd598);
        cyc();
        check_val("s_tmo_once", 32'(tmo_s), 32'd0);
        frame();
        check_val("s_adv_qidx", 32'(qidx_s), 32'd1);
        check_val("s_adv_qen", 32'(qen_s), 32'd2);
        check_val("s_adv_tl", 32'(tl_s), 32'd3);
        check_val("tl_597", 32'(tl), 32'd597);

        // T5: answer and expiring tick together
        frame();
        frame();
        check_val("s_tl_1b", 32'(tl_s), 32'd1);
        ans_valid_s = 1'b1; ans_correct = 1'b1;
        frame();
        ans_valid_s = 1'b0;
        check_val("s_race_score", 32'(score_s), 32'd1);
        check_val("s_race_tmo", 32'(tmo_s), 32'd0);
        check_val("s_race_tl", 32'(tl_s), 32'd1);
        cyc();
        check_val("s_race_tmo2", 32'(tmo_s), 32'd0);
        check_val("tl_594", 32'(tl), 32'd594);

        // start is ignored mid-quiz
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("start_ign_tl", 32'(tl), 32'd594);
        check_val("start_ign_qen", 32'(qen), 32'd2);

        // T6: answer remaining prompts correctly
        for (int q = 1; q < 4; q++) begin
            ans_valid = 1'b1; ans_correct = 1'b1;
            cyc();
            ans_valid = 1'b0;
            check_val("t6_score", 32'(score), 32'(q + 1));
            frame();
            if (q < 3) begin
                check_val("t6_qen", 32'(qen), 32'd1 << (q + 1));
            end else begin
                check_val("t6_done_qen", 32'(qen), 32'd0);
            end
        end
        check_val("t6_done", 32'(dn), 32'd1);
        check_val("t6_score4", 32'(score), 32'd4);
        check_val("t6_qidx", 32'(qidx), 32'd3);
        frame();
        check_val("done_hold_qen", 32'(qen), 32'd0);
        check_val("done_hold_score", 32'(score), 32'd4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("restart_done", 32'(dn), 32'd0);
        check_val("restart_score", 32'(score), 32'd0);
        check_val("restart_qidx", 32'(qidx), 32'd0);
        check_val("restart_tl", 32'(tl), 32'd600);
        frame();
        check_val("restart_qen", 32'(qen), 32'd1);

        // asynchronous reset mid-SHOW takes effect before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_qen", 32'(qen), 32'd0);
        check_val("async_rst_ready", 32'(rdy), 32'd0);
        check_val("async_rst_tl", 32'(tl), 32'd0);
        cyc();
        rst = 1'b0;
        frame();
        cyc();
        check_val("post_rst_qen", 32'(qen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
